// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with request/response imem port and decode FIFO
//
// Purpose:
//   Holds the fetch PC and issues word-aligned requests to a request/response
//   instruction memory. Up to MAX_OUTSTANDING requests may be in flight at once.
//   Returned words are buffered, together with their PCs, in a DEPTH-entry FIFO.
//   Decode drains that FIFO through a valid/ready handshake.
//   A redirect from execute flushes the FIFO and reloads both PCs. It also arranges
//   for every response still in flight to be discarded when it arrives.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_imem_req_valid/_addr       fetch request and its word address
//   i_imem_req_ready             memory accepts the request this cycle
//   i_imem_rsp_valid/_rdata      in-order response, never backpressured
//   i_redirect_valid/_pc         redirect fetch to a new PC
//   o_inst_valid/o_inst/o_inst_pc/o_inst_trap   FIFO head towards decode
//   i_inst_ready                 decode consumes the head
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  When defined, a redirect to a PC that is not word
//                           aligned halts fetch. It queues a single trap entry
//                           {pc, inst=0, trap=1}. When undefined, the low two
//                           redirect PC bits are ignored and o_inst_trap is tied
//                           to 0.

module fetch_queue #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_rdata,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_trap
);

    localparam int AW = $clog2(DEPTH);
    // Counter width with headroom, so that occupancy + in_flight (at most 2*DEPTH)
    // never overflows in the credit comparison.
    localparam int CW = AW + 2;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] drop_cnt;
    logic          halted;

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
    logic          mem_trap [DEPTH];
`endif

    logic [AW:0]   occupancy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [31:0]   redirect_pc;
    logic          misalign;
    logic          req_credit;
    logic          req_fire;
    logic          rsp_keep;
    logic          push;
    logic          pop;

    // Occupancy comes from the pointer difference. The extra wrap bit
    // distinguishes a full FIFO from an empty one.
    assign occupancy  = wr_ptr - rd_ptr;
    assign fifo_empty = (occupancy == '0);
    assign fifo_full  = (occupancy == (AW+1)'(DEPTH));
    assign rd_idx     = rd_ptr[AW-1:0];
    assign wr_idx     = wr_ptr[AW-1:0];

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_pc = i_redirect_pc;
    assign misalign    = (i_redirect_pc[1:0] != 2'b00);
`else
    logic [1:0] unused_redirect_low;
    assign unused_redirect_low = i_redirect_pc[1:0];
    assign redirect_pc         = {i_redirect_pc[31:2], 2'b00};
    assign misalign            = 1'b0;
`endif

    // A request may issue only if a FIFO slot is already reserved for its
    // response. Each in-flight request counts as a reserved slot, including
    // requests that are already marked to be dropped. This keeps the push side
    // from ever overflowing.
    assign req_credit = (in_flight < CW'(MAX_OUTSTANDING)) &&
                        ((CW'(occupancy) + in_flight) < CW'(DEPTH));

    assign o_imem_req_valid = !i_rst && !i_redirect_valid && !halted && req_credit;
    assign o_imem_req_addr  = fetch_pc;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    // A redirect in the same cycle overrides any push or pop, because the
    // clear takes priority.
    assign rsp_keep = i_imem_rsp_valid && (drop_cnt == '0);
    assign push     = rsp_keep && !i_redirect_valid;
    assign pop      = o_inst_valid && i_inst_ready && !i_redirect_valid;

    // The head is read straight from storage, with no bypass. A pushed word
    // therefore shows up the cycle after it arrives.
    assign o_inst_valid = !i_rst && !fifo_empty;
    assign o_inst       = o_inst_valid ? mem_inst[rd_idx] : 32'h0;
    assign o_inst_pc    = o_inst_valid ? mem_pc[rd_idx]   : 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign o_inst_trap  = o_inst_valid ? mem_trap[rd_idx] : 1'b0;
`else
    assign o_inst_trap  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc  <= RESET_ADDR;
            rsp_pc    <= RESET_ADDR;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            in_flight <= '0;
            drop_cnt  <= '0;
            halted    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= 32'h0;
                mem_pc[i]   <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
                mem_trap[i] <= 1'b0;
`endif
            end
        end else begin
            // No request issues during a redirect, so in_flight can only drop
            // in that cycle, and only if a response arrives.
            in_flight <= in_flight + CW'(req_fire) - CW'(i_imem_rsp_valid);

            if (i_redirect_valid) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                // Every request still outstanding after this edge is stale.
                // A response that arrives this cycle is discarded as well.
                drop_cnt <= in_flight - CW'(i_imem_rsp_valid);
                rd_ptr   <= '0;
                if (misalign) begin
                    // Replace the whole FIFO with a single trap entry in slot 0.
                    mem_inst[0] <= 32'h0;
                    mem_pc[0]   <= i_redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                    mem_trap[0] <= 1'b1;
`endif
                    wr_ptr      <= (AW+1)'(1);
                    halted      <= 1'b1;
                end else begin
                    wr_ptr      <= '0;
                    halted      <= 1'b0;
                end
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (i_imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    mem_inst[wr_idx] <= i_imem_rsp_rdata;
                    mem_pc[wr_idx]   <= rsp_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                    mem_trap[wr_idx] <= 1'b0;
`endif
                    wr_ptr           <= wr_ptr + (AW+1)'(1);
                    rsp_pc           <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
            end
        end
    end

    // The credit rule makes both of these impossible. If either fires, the
    // memory or this block has broken the request/response contract.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(push && fifo_full && !pop));
    a_no_rsp_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_imem_rsp_valid && (in_flight == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a queue-based model

module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_trap;

    always #5 clk = ~clk;

    fetch_queue #(
        .RESET_ADDR     (32'h0000_0000),
        .DEPTH          (DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .o_imem_req_valid(req_valid),
        .i_imem_req_ready(req_ready),
        .o_imem_req_addr (req_addr),
        .i_imem_rsp_valid(rsp_valid),
        .i_imem_rsp_rdata(rsp_rdata),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_inst_valid    (inst_valid),
        .i_inst_ready    (inst_ready),
        .o_inst          (inst),
        .o_inst_pc       (inst_pc),
        .o_inst_trap     (inst_trap)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; logic trap; } ent_t;

    // Model state: the requests outstanding at the memory, each tagged with the
    // redirect epoch it was issued in, and the entries decode should see.
    req_t        memq[$];
    ent_t        fifo[$];
    logic [31:0] m_pc;
    bit          m_halted;
    int          epoch, cyc, last_due, since_rst, fixed_k;
    int          tests, fails;
    int          fires, first_valid, max_infl;
    bit          last_inst_valid;
    logic [31:0] pop_log[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit r, input bit rr, input bit ir, input bit rv,
                         input logic [31:0] rpc, input int kmax);
        bit   rsp, fire, pop, exp_rv;
        req_t q;
        ent_t e;
        int   d;
        @(negedge clk);
        rst            = r;
        req_ready      = rr;
        inst_ready     = ir;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rsp            = !r && memq.size() > 0 && memq[0].due <= cyc;
        rsp_valid      = rsp;
        rsp_rdata      = rsp ? mem_data(memq[0].addr) : $urandom;
        #1;
        last_inst_valid = inst_valid;
        if (r) begin
            chk("rst_req_valid", {31'b0, req_valid}, 0);
            chk("rst_inst_valid", {31'b0, inst_valid}, 0);
            chk("rst_inst", inst, 0);
            chk("rst_inst_pc", inst_pc, 0);
            chk("rst_inst_trap", {31'b0, inst_trap}, 0);
            memq.delete();
            fifo.delete();
            m_pc = 32'h0; m_halted = 0; epoch++;
            since_rst = 0; first_valid = -1; fires = 0; max_infl = 0;
        end else begin
            since_rst++;
            exp_rv = !rv && !m_halted && memq.size() < MAXO && (fifo.size() + memq.size()) < DEPTH;
            chk("req_valid", {31'b0, req_valid}, {31'b0, exp_rv});
            if (exp_rv) chk("req_addr", req_addr, m_pc);
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, fifo.size() != 0});
            if (fifo.size() != 0) begin
                chk("inst", inst, fifo[0].word);
                chk("inst_pc", inst_pc, fifo[0].pc);
                chk("inst_trap", {31'b0, inst_trap}, {31'b0, fifo[0].trap});
            end
            fire = req_valid && rr;
            pop  = inst_valid && ir;
            if (fire) fires++;
            if (first_valid < 0 && inst_valid) first_valid = since_rst;
            if (pop && !rv) pop_log.push_back(inst_pc);
            if (rv) begin
                if (rsp) void'(memq.pop_front());
                epoch++;
                fifo.delete();
                m_halted = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc = rpc;
                if (rpc[1:0] != 2'b00) begin
                    e.pc = rpc; e.word = 32'h0; e.trap = 1'b1;
                    fifo.push_back(e);
                    m_halted = 1;
                end
`else
                m_pc = rpc & ~32'h3;
`endif
            end else begin
                if (pop && fifo.size() != 0) void'(fifo.pop_front());
                if (rsp) begin
                    q = memq.pop_front();
                    if (q.epoch == epoch) begin
                        e.pc = q.addr; e.word = mem_data(q.addr); e.trap = 1'b0;
                        fifo.push_back(e);
                    end
                end
                if (fire) begin
                    d = cyc + ((fixed_k > 0) ? fixed_k : int'($urandom_range(1, kmax)));
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    q.addr = m_pc; q.epoch = epoch; q.due = d;
                    memq.push_back(q);
                    m_pc += 32'd4;
                end
            end
            if (memq.size() > max_infl) max_infl = memq.size();
        end
        cyc++;
    endtask

    task automatic do_reset();
        repeat (3) cycle(1, 0, 0, 0, 32'h0, 1);
    endtask

    task automatic quiesce();
        for (int i = 0; i < 30 && memq.size() != 0; i++) cycle(0, 0, 1, 0, 32'h0, 1);
        chk("quiesce_drained", memq.size(), 0);
    endtask

    initial begin
        bit          hit;
        int          rr_p, ir_p, km;
        logic [31:0] r32, rpc;
        tests = 0; fails = 0; cyc = 0; epoch = 0; last_due = 0; fixed_k = 0;
        rst = 1; req_ready = 0; inst_ready = 0; redirect_valid = 0;
        redirect_pc = 0; rsp_valid = 0; rsp_rdata = 0;

        // Streaming with single-cycle memory: first word on the 3rd cycle, then one per cycle.
        do_reset();
        pop_log.delete();
        repeat (12) cycle(0, 1, 1, 0, 32'h0, 1);
        chk("first_valid_cycle", first_valid, 3);
        chk("first_pop_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk("stream_pops_in_12", pop_log.size(), 10);

        // Decode stalled: exactly DEPTH requests, then fetch stops; drain in order.
        quiesce();
        do_reset();
        repeat (10) cycle(0, 1, 0, 0, 32'h0, 1);
        chk("stall_fires", fires, 4);
        chk("stall_req_valid", {31'b0, req_valid}, 0);
        chk("stall_inst_valid", {31'b0, inst_valid}, 1);
        pop_log.delete();
        repeat (6) cycle(0, 1, 1, 0, 32'h0, 1);
        chk("drain_count", pop_log.size() >= 4, 1);
        if (pop_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("drain_pc", pop_log[i], 32'(4 * i));
        end

        // Three-cycle memory: never more than MAX_OUTSTANDING in flight.
        quiesce();
        do_reset();
        for (int i = 0; i < 40; i++) cycle(0, 1, $urandom_range(0, 1) == 1, 0, 32'h0, 3);
        chk("max_in_flight", max_infl <= MAXO, 1);

        // Redirect with two in flight and two buffered.
        quiesce();
        do_reset();
        fixed_k = 3;
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            if (fifo.size() == 2 && memq.size() == 2) begin hit = 1; break; end
            cycle(0, 1, 0, 0, 32'h0, 3);
        end
        fixed_k = 0;
        chk("setup_2buf_2infl", {31'b0, hit}, 1);
        cycle(0, 1, 1, 1, 32'h0000_0100, 3);
        cycle(0, 1, 0, 0, 32'h0, 3);
        chk("empty_after_redirect", {31'b0, last_inst_valid}, 0);
        pop_log.delete();
        repeat (15) cycle(0, 1, 1, 0, 32'h0, 3);
        chk("pc_after_redirect", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0100);

        // Redirect coinciding with a response and a decode pop.
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            if (memq.size() > 0 && memq[0].due <= cyc && fifo.size() > 0) begin
                cycle(0, 1, 1, 1, 32'h0000_0300, 2);
                hit = 1;
                break;
            end
            cycle(0, 1, $urandom_range(0, 1) == 1, 0, 32'h0, 2);
        end
        chk("redirect_rsp_pop_hit", {31'b0, hit}, 1);
        pop_log.delete();
        repeat (15) cycle(0, 1, 1, 0, 32'h0, 2);
        chk("pc_after_rsp_redirect", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0300);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect: one trap entry, then fetch halts until the next redirect.
        cycle(0, 1, 0, 1, 32'h0000_0102, 2);
        fires = 0;
        repeat (10) cycle(0, 1, 0, 0, 32'h0, 2);
        chk("trap_valid", {31'b0, inst_valid}, 1);
        chk("trap_flag", {31'b0, inst_trap}, 1);
        chk("trap_pc", inst_pc, 32'h0000_0102);
        chk("trap_no_fetch", fires, 0);
        cycle(0, 1, 1, 1, 32'h0000_0200, 2);
        pop_log.delete();
        repeat (15) cycle(0, 1, 1, 0, 32'h0, 2);
        chk("pc_after_trap", (pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h0000_0200);
`endif

        // Randomized phases, including redirects near the top of the address space.
        for (int ph = 0; ph < 15; ph++) begin
            rr_p = $urandom_range(1, 4);
            ir_p = $urandom_range(1, 4);
            km   = $urandom_range(1, 4);
            for (int i = 0; i < 200; i++) begin
                r32 = $urandom;
                rpc = r32 & ~32'h3;
                if ($urandom_range(0, 3) == 0) rpc = rpc | (r32 & 32'h3);
                if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
                cycle(0, $urandom_range(1, 4) <= rr_p, $urandom_range(1, 4) <= ir_p,
                      $urandom_range(0, 15) == 0, rpc, km);
            end
        end

        // Reset in mid-operation, then resume.
        quiesce();
        do_reset();
        for (int i = 0; i < 30; i++) cycle(0, 1, $urandom_range(0, 1) == 1, 0, 32'h0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
